piece_controller: RTL and testbench

PIECE_CONTROLLER -- requirements
Module: piece_controller

---
 rtl/piece_controller.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_piece_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_controller.sv
`default_nettype none
// ============================================================================
//  Module      : piece_controller
//  Description : Active-piece state machine for a falling-block game. Spawns
//                pieces from a fixed table, applies gravity, keyed moves with
//                delayed auto-repeat, and runs the grounded-piece lock timer.
//                Candidate positions are published for an external legality
//                checker that answers through can_move.
//  Revision    : 1.0 - initial release
// ============================================================================
module piece_controller #(
    parameter int COLS        = 10,
    parameter int ROWS        = 20,
    parameter int CW          = 5,
    parameter int DAS         = 3,
    parameter int ARR         = 1,
    parameter int LOCK_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              spawn_req,
    input  logic [2:0]        spawn_type,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_down,
    input  logic              key_rot_l,
    input  logic              key_rot_r,
    input  logic [5:0]        grav_period,
    input  logic [4:0]        can_move,
    input  logic [4*CW-1:0]   x_rot_l,
    input  logic [4*CW-1:0]   y_rot_l,
    input  logic [4*CW-1:0]   x_rot_r,
    input  logic [4*CW-1:0]   y_rot_r,
    output logic [4*CW-1:0]   x_block,
    output logic [4*CW-1:0]   y_block,
    output logic [4*CW-1:0]   x_left,
    output logic [4*CW-1:0]   x_right,
    output logic [4*CW-1:0]   y_down,
    output logic [1:0]        orientation,
    output logic              piece_active,
    output logic              spawn_ack,
    output logic              lock_pulse,
    output logic [2:0]        piece_type
);

    // Hold counters run 0..DAS+ARR-1, lock counter 0..LOCK_FRAMES.
    localparam int KW = $clog2(DAS + ARR + 1) + 1;
    localparam int LW = $clog2(LOCK_FRAMES + 2);
    localparam int X_OFF = COLS / 2 - 5;

    localparam logic [KW-1:0] c_DAS_K  = KW'(DAS);
    localparam logic [KW-1:0] c_WRAP_K = KW'(DAS + ARR - 1);
    localparam logic [KW-1:0] c_ONE_K  = KW'(1);
    localparam logic [LW-1:0] c_LOCK_K = LW'(LOCK_FRAMES);
    localparam logic [CW-1:0] c_ONE_C  = CW'(1);

    // Key index: 0 left, 1 right, 2 rot_l, 3 rot_r.
    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_ROTL  = 2;
    localparam int K_ROTR  = 3;

    // can_move bit positions: {left,right,rot_l,rot_r,down}.
    localparam int M_DOWN  = 0;
    localparam int M_ROTR  = 1;
    localparam int M_ROTL  = 2;
    localparam int M_RIGHT = 3;
    localparam int M_LEFT  = 4;

    generate
        if (($clog2(COLS) > CW) || ($clog2(ROWS) > CW)) begin : g_bad_params
            $error("piece_controller: CW too narrow for COLS/ROWS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FALL    = 2'd1,
        ST_LOCKING = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [4*CW-1:0]   x_q, x_d;
    logic [4*CW-1:0]   y_q, y_d;
    logic [1:0]        orient_q, orient_d;
    logic [2:0]        type_q, type_d;
    logic [5:0]        grav_q, grav_d;
    logic [LW-1:0]     lock_q, lock_d;
    logic [KW-1:0]     hold_q [4];
    logic [KW-1:0]     hold_d [4];
    logic              ack_q, ack_d;
    logic              lpulse_q, lpulse_d;

    logic [3:0]        w_keys;
    logic [3:0]        w_fire;
    logic [KW-1:0]     w_hold_next [4];
    logic [5:0]        w_eff_period;
    logic [5:0]        w_grav_inc;
    logic              w_grav_due;
    logic [LW-1:0]     w_lock_inc;

    // Pack four cell coordinates, cell 0 in the least significant slot.
    function automatic logic [4*CW-1:0] pack_cells(input int c0, input int c1,
                                                   input int c2, input int c3,
                                                   input int off);
        logic [4*CW-1:0] r;
        r[0*CW +: CW] = CW'(c0 + off);
        r[1*CW +: CW] = CW'(c1 + off);
        r[2*CW +: CW] = CW'(c2 + off);
        r[3*CW +: CW] = CW'(c3 + off);
        return r;
    endfunction

    function automatic logic [4*CW-1:0] spawn_x(input logic [2:0] t);
        case (t)
            3'd0:    return pack_cells(3, 4, 5, 6, X_OFF);
            3'd1:    return pack_cells(4, 4, 5, 6, X_OFF);
            3'd2:    return pack_cells(6, 6, 5, 4, X_OFF);
            3'd3:    return pack_cells(4, 5, 4, 5, X_OFF);
            3'd4:    return pack_cells(6, 5, 5, 4, X_OFF);
            3'd5:    return pack_cells(4, 5, 5, 6, X_OFF);
            default: return pack_cells(4, 5, 5, 6, X_OFF);
        endcase
    endfunction

    function automatic logic [4*CW-1:0] spawn_y(input logic [2:0] t);
        case (t)
            3'd0:    return pack_cells(0, 0, 0, 0, 0);
            3'd1:    return pack_cells(0, 1, 1, 1, 0);
            3'd2:    return pack_cells(0, 1, 1, 1, 0);
            3'd3:    return pack_cells(0, 0, 1, 1, 0);
            3'd4:    return pack_cells(0, 0, 1, 1, 0);
            3'd5:    return pack_cells(1, 0, 1, 1, 0);
            default: return pack_cells(0, 1, 0, 1, 0);
        endcase
    endfunction

    // Translation candidates per cell, wrapping in CW bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign x_left [gi*CW +: CW] = x_q[gi*CW +: CW] - c_ONE_C;
            assign x_right[gi*CW +: CW] = x_q[gi*CW +: CW] + c_ONE_C;
            assign y_down [gi*CW +: CW] = y_q[gi*CW +: CW] + c_ONE_C;
        end
    endgenerate

    assign w_keys = {key_rot_r, key_rot_l, key_right, key_left};

    // Key repeat: fire on first sight, then at DAS, then every ARR; the
    // translation counters wrap inside [DAS, DAS+ARR-1], rotation counters
    // saturate at 1 so rotations fire once per press.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_fire[k]      = 1'b0;
            w_hold_next[k] = '0;
            if (w_keys[k]) begin
                if (k < 2) begin
                    w_fire[k]      = (hold_q[k] == '0) || (hold_q[k] == c_DAS_K);
                    w_hold_next[k] = (hold_q[k] == c_WRAP_K) ? c_DAS_K
                                                              : hold_q[k] + c_ONE_K;
                end else begin
                    w_fire[k]      = (hold_q[k] == '0);
                    w_hold_next[k] = c_ONE_K;
                end
            end
        end
    end

    assign w_eff_period = key_down ? 6'd1 : ((grav_period == 6'd0) ? 6'd1 : grav_period);
    assign w_grav_inc   = grav_q + 6'd1;
    assign w_grav_due   = (w_grav_inc >= w_eff_period);
    assign w_lock_inc   = lock_q + LW'(1);

    // Next-state: spawn in IDLE, one move per frame tick, lock timing.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        orient_d = orient_q;
        type_d   = type_q;
        grav_d   = grav_q;
        lock_d   = lock_q;
        ack_d    = 1'b0;
        lpulse_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hold_d[k] = hold_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (spawn_req && (spawn_type != 3'd7)) begin
                    state_d  = ST_FALL;
                    x_d      = spawn_x(spawn_type);
                    y_d      = spawn_y(spawn_type);
                    orient_d = 2'd0;
                    type_d   = spawn_type;
                    grav_d   = '0;
                    lock_d   = '0;
                    ack_d    = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        hold_d[k] = '0;
                    end
                end
            end

            ST_FALL, ST_LOCKING: begin
                if (frame_tick) begin
                    grav_d = w_grav_due ? 6'd0 : w_grav_inc;
                    for (int k = 0; k < 4; k++) begin
                        hold_d[k] = w_hold_next[k];
                    end

                    if (w_grav_due) begin
                        // Gravity owns this tick whether or not down is legal.
                        if (can_move[M_DOWN]) begin
                            y_d     = y_down;
                            state_d = ST_FALL;
                            lock_d  = '0;
                        end else if (state_q == ST_FALL) begin
                            state_d = ST_LOCKING;
                            lock_d  = '0;
                        end
                    end else if (w_fire[K_ROTL]) begin
                        if (can_move[M_ROTL]) begin
                            x_d      = x_rot_l;
                            y_d      = y_rot_l;
                            orient_d = orient_q - 2'd1;
                        end
                    end else if (w_fire[K_ROTR]) begin
                        if (can_move[M_ROTR]) begin
                            x_d      = x_rot_r;
                            y_d      = y_rot_r;
                            orient_d = orient_q + 2'd1;
                        end
                    end else if (w_fire[K_RIGHT]) begin
                        if (can_move[M_RIGHT]) begin
                            x_d = x_right;
                        end
                    end else if (w_fire[K_LEFT]) begin
                        if (can_move[M_LEFT]) begin
                            x_d = x_left;
                        end
                    end

                    // Lock timer keeps running through sideways moves and
                    // rotations; only a successful drop cancels it.
                    if ((state_q == ST_LOCKING) && !(w_grav_due && can_move[M_DOWN])) begin
                        lock_d = w_lock_inc;
                        if (w_lock_inc >= c_LOCK_K) begin
                            state_d  = ST_LOCKED;
                            lpulse_d = 1'b1;
                        end
                    end
                end
            end

            ST_LOCKED: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            orient_q <= 2'd0;
            type_q   <= 3'd0;
            grav_q   <= '0;
            lock_q   <= '0;
            ack_q    <= 1'b0;
            lpulse_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            orient_q <= orient_d;
            type_q   <= type_d;
            grav_q   <= grav_d;
            lock_q   <= lock_d;
            ack_q    <= ack_d;
            lpulse_q <= lpulse_d;
            for (int k = 0; k < 4; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    assign x_block      = x_q;
    assign y_block      = y_q;
    assign orientation  = orient_q;
    assign piece_type   = type_q;
    assign spawn_ack    = ack_q;
    assign lock_pulse   = lpulse_q;
    assign piece_active = (state_q == ST_FALL) || (state_q == ST_LOCKING);

endmodule
`default_nettype wire

// File: tb/tb_piece_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piece_controller
//  Description : Self-checking bench for piece_controller. A behavioural model
//                of the piece rules is stepped alongside the DUT and every
//                output is compared each cycle; directed scenarios add literal
//                expectations, followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piece_controller;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CW   = 5;
    localparam int DAS  = 3;
    localparam int ARR  = 1;
    localparam int LF   = 6;
    localparam int MASK = (1 << CW) - 1;

    localparam int M_IDLE = 0, M_FALL = 1, M_LOCKING = 2, M_LOCKED = 3;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            frame_tick, spawn_req;
    logic [2:0]      spawn_type;
    logic            key_left, key_right, key_down, key_rot_l, key_rot_r;
    logic [5:0]      grav_period;
    logic [4:0]      can_move;
    logic [4*CW-1:0] x_rot_l, y_rot_l, x_rot_r, y_rot_r;
    logic [4*CW-1:0] x_block, y_block, x_left, x_right, y_down;
    logic [1:0]      orientation;
    logic            piece_active, spawn_ack, lock_pulse;
    logic [2:0]      piece_type;

    piece_controller #(
        .COLS(COLS), .ROWS(ROWS), .CW(CW), .DAS(DAS), .ARR(ARR), .LOCK_FRAMES(LF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .spawn_req(spawn_req), .spawn_type(spawn_type),
        .key_left(key_left), .key_right(key_right), .key_down(key_down),
        .key_rot_l(key_rot_l), .key_rot_r(key_rot_r),
        .grav_period(grav_period), .can_move(can_move),
        .x_rot_l(x_rot_l), .y_rot_l(y_rot_l), .x_rot_r(x_rot_r), .y_rot_r(y_rot_r),
        .x_block(x_block), .y_block(y_block),
        .x_left(x_left), .x_right(x_right), .y_down(y_down),
        .orientation(orientation), .piece_active(piece_active),
        .spawn_ack(spawn_ack), .lock_pulse(lock_pulse), .piece_type(piece_type)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int ms, mo, mt, mg, ml;
    int mx[4], my[4], mh[4];
    bit mack, mlock;

    int bx[7][4] = '{'{3,4,5,6}, '{4,4,5,6}, '{6,6,5,4}, '{4,5,4,5},
                     '{6,5,5,4}, '{4,5,5,6}, '{4,5,5,6}};
    int by[7][4] = '{'{0,0,0,0}, '{0,1,1,1}, '{0,1,1,1}, '{0,0,1,1},
                     '{0,0,1,1}, '{1,0,1,1}, '{0,1,0,1}};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4*CW-1:0] packv(input int v0, input int v1,
                                              input int v2, input int v3, input int d);
        logic [4*CW-1:0] r;
        r[0*CW +: CW] = CW'((v0 + d) & MASK);
        r[1*CW +: CW] = CW'((v1 + d) & MASK);
        r[2*CW +: CW] = CW'((v2 + d) & MASK);
        r[3*CW +: CW] = CW'((v3 + d) & MASK);
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int  eff;
        bit  due, was_locking;
        bit  f[4];
        bit  kv[4];
        mack  = 0;
        mlock = 0;
        if (Reset) begin
            ms = M_IDLE; mo = 0; mt = 0; mg = 0; ml = 0;
            for (int i = 0; i < 4; i++) begin mx[i] = 0; my[i] = 0; mh[i] = 0; end
            return;
        end
        case (ms)
            M_IDLE: begin
                if (spawn_req && spawn_type != 3'd7) begin
                    for (int i = 0; i < 4; i++) begin
                        mx[i] = (bx[spawn_type][i] + COLS/2 - 5) & MASK;
                        my[i] = by[spawn_type][i];
                        mh[i] = 0;
                    end
                    mo = 0; mt = spawn_type; mg = 0; ml = 0;
                    ms = M_FALL; mack = 1;
                end
            end
            M_FALL, M_LOCKING: begin
                if (frame_tick) begin
                    mg++;
                    eff = key_down ? 1 : ((grav_period == 0) ? 1 : int'(grav_period));
                    due = (mg >= eff);
                    if (due) mg = 0;
                    kv[0] = key_left; kv[1] = key_right; kv[2] = key_rot_l; kv[3] = key_rot_r;
                    for (int k = 0; k < 4; k++) begin
                        if (kv[k]) begin
                            f[k] = (mh[k] == 0) ||
                                   (k < 2 && mh[k] >= DAS && ((mh[k] - DAS) % ARR) == 0);
                            mh[k]++;
                        end else begin
                            f[k]  = 0;
                            mh[k] = 0;
                        end
                    end
                    was_locking = (ms == M_LOCKING);
                    if (due) begin
                        if (can_move[0]) begin
                            for (int i = 0; i < 4; i++) my[i] = (my[i] + 1) & MASK;
                            ms = M_FALL; ml = 0;
                        end else if (ms == M_FALL) begin
                            ms = M_LOCKING; ml = 0;
                        end
                    end else if (f[2]) begin
                        if (can_move[2]) begin
                            for (int i = 0; i < 4; i++) begin
                                mx[i] = int'(x_rot_l[i*CW +: CW]); my[i] = int'(y_rot_l[i*CW +: CW]);
                            end
                            mo = (mo + 3) % 4;
                        end
                    end else if (f[3]) begin
                        if (can_move[1]) begin
                            for (int i = 0; i < 4; i++) begin
                                mx[i] = int'(x_rot_r[i*CW +: CW]); my[i] = int'(y_rot_r[i*CW +: CW]);
                            end
                            mo = (mo + 1) % 4;
                        end
                    end else if (f[1]) begin
                        if (can_move[3]) for (int i = 0; i < 4; i++) mx[i] = (mx[i] + 1) & MASK;
                    end else if (f[0]) begin
                        if (can_move[4]) for (int i = 0; i < 4; i++) mx[i] = (mx[i] - 1) & MASK;
                    end
                    if (was_locking && !(due && can_move[0])) begin
                        ml++;
                        if (ml >= LF) begin ms = M_LOCKED; mlock = 1; end
                    end
                end
            end
            default: ms = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("x_block",      x_block, packv(mx[0], mx[1], mx[2], mx[3], 0));
        chk("y_block",      y_block, packv(my[0], my[1], my[2], my[3], 0));
        chk("x_left",       x_left,  packv(mx[0], mx[1], mx[2], mx[3], -1));
        chk("x_right",      x_right, packv(mx[0], mx[1], mx[2], mx[3], 1));
        chk("y_down",       y_down,  packv(my[0], my[1], my[2], my[3], 1));
        chk("orientation",  orientation, mo[1:0]);
        chk("piece_type",   piece_type, mt[2:0]);
        chk("piece_active", piece_active, (ms == M_FALL || ms == M_LOCKING));
        chk("spawn_ack",    spawn_ack, mack);
        chk("lock_pulse",   lock_pulse, mlock);
    endtask

    task automatic step();
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic defaults();
        frame_tick = 0; spawn_req = 0; spawn_type = 0;
        key_left = 0; key_right = 0; key_down = 0; key_rot_l = 0; key_rot_r = 0;
        grav_period = 6'd4; can_move = 5'b11111;
        x_rot_l = '0; y_rot_l = '0; x_rot_r = '0; y_rot_r = '0;
    endtask

    task automatic do_reset();
        Reset = 1; frame_tick = 0; spawn_req = 0;
        step();
        Reset = 0;
    endtask

    task automatic spawn(input logic [2:0] t);
        frame_tick = 0; spawn_req = 1; spawn_type = t;
        step();
        spawn_req = 0;
    endtask

    int exp_x0[8] = '{4, 4, 4, 5, 6, 7, 8, 9};
    int cnt;
    bit seen;
    int pulses;
    int bias;

    initial begin
        defaults();
        Reset = 1;
        step();
        step();
        Reset = 0;
        chk("reset_x", x_block, '0);
        chk("reset_active", piece_active, 1'b0);

        // T spawn
        spawn(3'd5);
        chk("t_ack", spawn_ack, 1'b1);
        chk("t_x", x_block, {5'd6, 5'd5, 5'd5, 5'd4});
        chk("t_y", y_block, {5'd1, 5'd1, 5'd0, 5'd1});
        chk("t_active", piece_active, 1'b1);
        chk("t_type", piece_type, 3'd5);
        step();
        chk("t_ack_once", spawn_ack, 1'b0);

        // Gravity every 4 ticks for 12 ticks: three rows.
        grav_period = 6'd4; frame_tick = 1;
        repeat (12) step();
        frame_tick = 0;
        chk("grav_y", y_block, {5'd4, 5'd4, 5'd3, 5'd4});

        // Held right with DAS=3, ARR=1.
        do_reset();
        spawn(3'd0);
        grav_period = 6'd60; key_right = 1; frame_tick = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("das_x0", x_block[CW-1:0], exp_x0[i][CW-1:0]);
        end
        key_right = 0; frame_tick = 0;
        chk("das_x", x_block, {5'd12, 5'd11, 5'd10, 5'd9});

        // Grounded piece locks LF ticks after entering LOCKING.
        do_reset();
        spawn(3'd3);
        can_move = 5'b11110; grav_period = 6'd1; frame_tick = 1;
        cnt = 0; seen = 0;
        while (!seen && cnt < 100) begin
            step(); cnt++;
            if (lock_pulse) seen = 1;
        end
        chk("lock_latency", cnt, LF + 1);
        chk("locked_inactive", piece_active, 1'b0);
        step();
        chk("idle_inactive", piece_active, 1'b0);
        chk("idle_no_pulse", lock_pulse, 1'b0);
        chk("held_x", x_block, {5'd5, 5'd4, 5'd5, 5'd4});
        chk("held_y", y_block, {5'd1, 5'd1, 5'd0, 5'd0});
        frame_tick = 0;

        // Drop during LOCKING returns to FALL with a fresh lock timer.
        do_reset();
        spawn(3'd1);
        can_move = 5'b11110; grav_period = 6'd1; frame_tick = 1;
        repeat (3) step();
        can_move = 5'b11111;
        step();
        chk("relock_y", y_block, {5'd2, 5'd2, 5'd2, 5'd1});
        chk("relock_active", piece_active, 1'b1);
        can_move = 5'b11110;
        cnt = 0; seen = 0;
        while (!seen && cnt < 100) begin
            step(); cnt++;
            if (lock_pulse) seen = 1;
        end
        chk("relock_latency", cnt, LF + 1);
        frame_tick = 0;

        // Reset in the middle of LOCKING.
        do_reset();
        spawn(3'd6);
        can_move = 5'b11110; grav_period = 6'd1; frame_tick = 1;
        repeat (3) step();
        Reset = 1;
        step();
        Reset = 0;
        chk("mid_rst_x", x_block, '0);
        chk("mid_rst_y", y_block, '0);
        chk("mid_rst_or", orientation, 2'd0);
        chk("mid_rst_type", piece_type, 3'd0);
        chk("mid_rst_active", piece_active, 1'b0);
        pulses = 0;
        repeat (LF + 5) begin
            step();
            if (lock_pulse) pulses++;
        end
        chk("mid_rst_no_lock", pulses, 0);
        defaults();

        // Randomized run.
        bias = 90;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) bias = ($urandom_range(0, 1) != 0) ? 90 : 35;
            Reset      = ($urandom_range(0, 599) == 0);
            frame_tick = ($urandom_range(0, 1) != 0);
            spawn_req  = ($urandom_range(0, 2) == 0);
            spawn_type = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) key_left  = ~key_left;
            if ($urandom_range(0, 3) == 0) key_right = ~key_right;
            if ($urandom_range(0, 5) == 0) key_down  = ~key_down;
            if ($urandom_range(0, 3) == 0) key_rot_l = ~key_rot_l;
            if ($urandom_range(0, 3) == 0) key_rot_r = ~key_rot_r;
            if ($urandom_range(0, 15) == 0) grav_period = 6'($urandom_range(0, 5));
            can_move[0] = ($urandom_range(0, 99) < bias);
            for (int b = 1; b < 5; b++) can_move[b] = ($urandom_range(0, 3) != 0);
            x_rot_l = 20'($urandom); y_rot_l = 20'($urandom);
            x_rot_r = 20'($urandom); y_rot_r = 20'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
